// File: rtl/rpn_stack_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the RPN stack sequencer.
package rpn_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_PUSHI = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_DUP   = 3'd6;
    localparam logic [2:0] OP_DROP  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_POP_B,
        ST_POP_A,
        ST_EXEC,
        ST_PUSH_R,
        ST_PUSH_R2,
        ST_RESP
    } state_t;

    function automatic logic op_is_binary(input logic [2:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/rpn_stack_sequencer_if.sv
// Command, response and stack-request signals of the RPN sequencer, bundled for port use.
interface rpn_stack_sequencer_if #(
    parameter int DEPTH = 16
) ();
    localparam int DW = $clog2(DEPTH + 1);

    // Handshakes: a command transfers on a cycle where cmd_valid & cmd_ready are both high.
    // stk_push / stk_pop are level requests held until a one-cycle stk_ack; a pop's data is
    // valid in the ack cycle. rsp_valid is a one-cycle strobe with no back-pressure.
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [7:0]    cmd_imm;
    logic          stk_push;
    logic          stk_pop;
    logic [7:0]    stk_wdata;
    logic [7:0]    stk_rdata;
    logic          stk_ack;
    logic          rsp_valid;
    logic [7:0]    rsp_data;
    logic          rsp_err;
    logic          flag_z;
    logic          flag_c;
    logic [DW-1:0] depth;

    modport master (
        input  cmd_valid, cmd_op, cmd_imm, stk_rdata, stk_ack,
        output cmd_ready, stk_push, stk_pop, stk_wdata,
               rsp_valid, rsp_data, rsp_err, flag_z, flag_c, depth
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_imm, stk_rdata, stk_ack,
        input  cmd_ready, stk_push, stk_pop, stk_wdata,
               rsp_valid, rsp_data, rsp_err, flag_z, flag_c, depth
    );

endinterface

// File: rtl/rpn_stack_sequencer_alu.sv
// Combinational 8-bit ALU step; c is ADD carry-out or SUB borrow, 0 for logic ops.
module rpn_alu
    import rpn_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       c
);
    logic [8:0] sum;
    logic [8:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        // bit 8 of the 9-bit difference is set exactly when a < b
        diff = {1'b0, a} - {1'b0, b};
        y    = '0;
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                y = sum[7:0];
                c = sum[8];
            end
            OP_SUB: begin
                y = diff[7:0];
                c = diff[8];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN command front end: expands each opcode into stack pops/pushes around one ALU step
// and returns one response per command.
module rpn_stack_sequencer
    import rpn_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rpn_stack_sequencer_if.master bus,
    output state_t               dbg_state
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] DEPTH_TWO = DW'(2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    state_t        state_q;
    logic [2:0]    op_q;
    logic [7:0]    imm_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [7:0]    res_q;
    logic          res_c_q;
    logic [DW-1:0] depth_q;
    logic [TW-1:0] tmo_q;

    logic          cmd_ready_q;
    logic          push_q;
    logic          pop_q;
    logic [7:0]    wdata_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic          rsp_err_q;
    logic          flag_z_q;
    logic          flag_c_q;

    logic [7:0]    alu_y;
    logic          alu_c;
    logic          check_ok;
    logic          tmo_hit;
    logic [7:0]    exec_res;

    rpn_alu u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y),
        .c  (alu_c)
    );

    always_comb begin
        check_ok = 1'b0;
        if (op_is_binary(op_q)) begin
            check_ok = (depth_q >= DEPTH_TWO);
        end else begin
            case (op_q)
                OP_DUP:  check_ok = (depth_q != '0) && (depth_q < DEPTH_MAX);
                OP_DROP: check_ok = (depth_q != '0);
                default: check_ok = (depth_q < DEPTH_MAX);
            endcase
        end
    end

    // DUP and DROP both report the popped top, held in b_q.
    always_comb begin
        exec_res = b_q;
        if (op_is_binary(op_q)) begin
            exec_res = alu_y;
        end else if (op_q == OP_PUSHI) begin
            exec_res = imm_q;
        end
    end

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PUSHI;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            res_c_q     <= 1'b0;
            depth_q     <= '0;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b1;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= bus.cmd_op;
                        imm_q       <= bus.cmd_imm;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!check_ok) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else if (op_q == OP_PUSHI) begin
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_POP_B;
                        pop_q   <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                ST_POP_B: begin
                    if (bus.stk_ack) begin
                        b_q     <= bus.stk_rdata;
                        depth_q <= depth_q - DW'(1);
                        tmo_q   <= '0;
                        if (op_is_binary(op_q)) begin
                            state_q <= ST_POP_A;
                        end else begin
                            pop_q   <= 1'b0;
                            state_q <= ST_EXEC;
                        end
                    end else if (tmo_hit) begin
                        pop_q       <= 1'b0;
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_POP_A: begin
                    if (bus.stk_ack) begin
                        a_q     <= bus.stk_rdata;
                        depth_q <= depth_q - DW'(1);
                        pop_q   <= 1'b0;
                        state_q <= ST_EXEC;
                    end else if (tmo_hit) begin
                        pop_q       <= 1'b0;
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_EXEC: begin
                    res_q   <= exec_res;
                    res_c_q <= alu_c;
                    if (op_q == OP_DROP) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= exec_res;
                    end else begin
                        push_q  <= 1'b1;
                        wdata_q <= exec_res;
                        tmo_q   <= '0;
                        state_q <= ST_PUSH_R;
                    end
                end
                ST_PUSH_R, ST_PUSH_R2: begin
                    if (bus.stk_ack) begin
                        depth_q <= depth_q + DW'(1);
                        tmo_q   <= '0;
                        if (state_q == ST_PUSH_R && op_q == OP_DUP) begin
                            state_q <= ST_PUSH_R2;
                        end else begin
                            push_q      <= 1'b0;
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= res_q;
                            // flags reflect only arithmetic/logic ops that fully completed
                            if (op_is_binary(op_q)) begin
                                flag_z_q <= (res_q == 8'd0);
                                flag_c_q <= res_c_q;
                            end
                        end
                    end else if (tmo_hit) begin
                        push_q      <= 1'b0;
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    push_q      <= 1'b0;
                    pop_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.stk_push  = push_q;
    assign bus.stk_pop   = pop_q;
    assign bus.stk_wdata = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.depth     = depth_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Randomized scoreboard bench for rpn_stack_sequencer with a queue-based stack model.
module tb_rpn_stack_sequencer;
    import rpn_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int DW      = $clog2(DEPTH + 1);
    // entry: {req_mode[1:0], err, data[7:0], z, c, depth}
    localparam int W       = DW + 13;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    rpn_stack_sequencer_if #(.DEPTH(DEPTH)) bus ();

    rpn_stack_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    logic [7:0]   m_stk[$];
    logic         m_z = 1'b0;
    logic         m_c = 1'b0;

    logic [7:0]   mem[$];
    logic [8:0]   log_q[$];
    int lat = 1;
    int acks_limit = -1;
    int cmd_id = 0;
    int stale_req = 0;
    int req_cycles = 0;
    int acc_cyc = 0;
    int last_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stack emulator: acks each request `lat` cycles after it first appears.
    initial begin : stack_emu
        int wait_cnt;
        int seen_id;
        int acks_given;
        int stale_done;
        wait_cnt = 0; seen_id = 0; acks_given = 0; stale_done = 0;
        bus.stk_ack = 1'b0;
        bus.stk_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.stk_ack = 1'b0;
                wait_cnt = 0;
                mem.delete();
                log_q.delete();
                stale_done = stale_req;
            end else if (stale_req != stale_done) begin
                stale_done = stale_req;
                bus.stk_ack = 1'b1;
            end else begin
                if (cmd_id != seen_id) begin
                    seen_id = cmd_id;
                    acks_given = 0;
                    req_cycles = 0;
                end
                if (bus.stk_ack) begin
                    bus.stk_ack = 1'b0;
                    wait_cnt = 0;
                end
                if (bus.stk_push || bus.stk_pop) begin
                    req_cycles++;
                    wait_cnt++;
                    if ((acks_limit < 0 || acks_given < acks_limit) && wait_cnt > lat) begin
                        bus.stk_ack = 1'b1;
                        acks_given++;
                        if (bus.stk_push) begin
                            mem.push_back(bus.stk_wdata);
                            log_q.push_back({1'b1, bus.stk_wdata});
                        end else begin
                            bus.stk_rdata = (mem.size() > 0) ? mem.pop_back() : 8'h00;
                            log_q.push_back({1'b0, bus.stk_rdata});
                        end
                    end
                end
            end
        end
    end

    // Reference model: whole-command semantics on a queue.
    task automatic model_cmd(input logic [2:0] op, input logic [7:0] imm, input bit hold);
        int n;
        int s;
        bit ok;
        bit err;
        logic [1:0] mode;
        logic [7:0] a, b, y, d;
        n = m_stk.size();
        d = 8'h00;
        case (op)
            OP_PUSHI: ok = (n < DEPTH);
            OP_DUP:   ok = (n >= 1) && (n < DEPTH);
            OP_DROP:  ok = (n >= 1);
            default:  ok = (n >= 2);
        endcase
        mode = !ok ? 2'd1 : (hold ? 2'd2 : 2'd0);
        err = !ok || hold;
        if (!err) begin
            case (op)
                OP_PUSHI: begin m_stk.push_back(imm); d = imm; end
                OP_DUP:   begin d = m_stk[$]; m_stk.push_back(d); end
                OP_DROP:  d = m_stk.pop_back();
                default: begin
                    b = m_stk.pop_back();
                    a = m_stk.pop_back();
                    y = 8'h00;
                    m_c = 1'b0;
                    case (op)
                        OP_ADD: begin s = int'(a) + int'(b); y = 8'(s % 256); m_c = (s > 255); end
                        OP_SUB: begin s = int'(a) - int'(b) + 256; y = 8'(s % 256); m_c = (a < b); end
                        OP_AND: y = a & b;
                        OP_OR:  y = a | b;
                        default: y = a ^ b;
                    endcase
                    m_z = (y == 8'h00);
                    m_stk.push_back(y);
                    d = y;
                end
            endcase
        end
        exp_q.push_back({mode, err, d, m_z, m_c, DW'(m_stk.size())});
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] imm, input int acks, input int l);
        int guard;
        model_cmd(op, imm, acks == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_imm = imm;
        guard = 0;
        while (!bus.cmd_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.cmd_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles, required 1", guard);
        end
        @(posedge clk); #1;
        acc_cyc = cyc - 1;
        acks_limit = acks;
        lat = l;
        cmd_id++;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && bus.cmd_ready) && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 400) begin
            checks++; failures++;
            $display("FAIL idle_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        exp_q.delete();
        m_stk.delete();
        m_z = 1'b0;
        m_c = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Monitor: pops one expectation per response strobe.
    logic [W-1:0] mon_e;
    always @(negedge clk) begin
        if (rst_n && (bus.stk_push || bus.stk_pop))
            check("push_pop_exclusive", bus.stk_push & bus.stk_pop, 0);
        if (rst_n && bus.rsp_valid) begin
            last_lat = cyc - acc_cyc;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_unexpected: got response data 0x%0h, required none", bus.rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_err", bus.rsp_err, mon_e[DW+10]);
                check("rsp_data", bus.rsp_data, mon_e[DW+9:DW+2]);
                check("flag_z", bus.flag_z, mon_e[DW+1]);
                check("flag_c", bus.flag_c, mon_e[DW]);
                check("depth", bus.depth, mon_e[DW-1:0]);
                check("stack_contents_size", mem.size(), mon_e[DW-1:0]);
                check("cmd_ready_in_resp", bus.cmd_ready, 0);
                if (mon_e[DW+12:DW+11] == 2'd1) check("no_stack_request", req_cycles, 0);
                if (mon_e[DW+12:DW+11] == 2'd2) check("timeout_hold_cycles", req_cycles, TIMEOUT);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [8:0] exp_log[5];
        logic [7:0] last_imm;
        logic [2:0] rop;
        int guard;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0;
        bus.cmd_imm = 8'h00;
        #12;
        check("reset_cmd_ready", bus.cmd_ready, 1);
        check("reset_push", bus.stk_push, 0);
        check("reset_pop", bus.stk_pop, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_flags", {bus.flag_z, bus.flag_c}, 0);
        check("reset_depth", bus.depth, 0);
        do_reset();

        // 1: PUSHI 5, PUSHI 3, ADD with one-cycle ack
        send_cmd(OP_PUSHI, 8'd5, -1, 1); wait_idle();
        check("latency_pushi", last_lat, 5);
        send_cmd(OP_PUSHI, 8'd3, -1, 1); wait_idle();
        send_cmd(OP_ADD, 8'd0, -1, 1); wait_idle();
        check("latency_add", last_lat, 9);
        exp_log[0] = {1'b1, 8'd5}; exp_log[1] = {1'b1, 8'd3};
        exp_log[2] = {1'b0, 8'd3}; exp_log[3] = {1'b0, 8'd5}; exp_log[4] = {1'b1, 8'd8};
        check("stack_op_count", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) check("stack_op_seq", log_q[i], exp_log[i]);

        // 2: SUB with borrow, then XOR to zero
        send_cmd(OP_PUSHI, 8'd3, -1, 1);
        send_cmd(OP_PUSHI, 8'd5, -1, 2);
        send_cmd(OP_SUB, 8'd0, -1, 1);
        send_cmd(OP_PUSHI, 8'hFE, -1, 3);
        send_cmd(OP_XOR, 8'd0, -1, 1);
        wait_idle();

        // 3: binary op on a one-entry stack
        do_reset();
        send_cmd(OP_PUSHI, 8'd7, -1, 1);
        send_cmd(OP_ADD, 8'd0, -1, 1);
        wait_idle();

        // 4: full stack
        do_reset();
        last_imm = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last_imm = 8'($urandom_range(0, 255));
            send_cmd(OP_PUSHI, last_imm, -1, $urandom_range(1, 3));
        end
        send_cmd(OP_DUP, 8'd0, -1, 1);
        send_cmd(OP_PUSHI, 8'hAA, -1, 1);
        send_cmd(OP_DROP, 8'd0, -1, 1);
        wait_idle();
        check("full_drop_depth", bus.depth, DEPTH - 1);

        // 5: pop never acknowledged
        do_reset();
        send_cmd(OP_PUSHI, 8'd9, -1, 1);
        send_cmd(OP_DROP, 8'd0, 0, 1);
        send_cmd(OP_PUSHI, 8'h11, -1, 1);
        wait_idle();

        // 6: reset while waiting in POP_A, then a stale ack
        do_reset();
        send_cmd(OP_PUSHI, 8'd1, -1, 1);
        send_cmd(OP_PUSHI, 8'd2, -1, 1);
        wait_idle();
        send_cmd(OP_ADD, 8'd0, 1, 1);
        guard = 0;
        while (dbg_state != ST_POP_A && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reach_pop_a", dbg_state == ST_POP_A, 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_cmd_ready", bus.cmd_ready, 1);
        check("midop_reset_pop", bus.stk_pop, 0);
        check("midop_reset_rsp_valid", bus.rsp_valid, 0);
        check("midop_reset_depth", bus.depth, 0);
        exp_q.delete();
        m_stk.delete();
        m_z = 1'b0;
        m_c = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        stale_req++;
        repeat (4) @(posedge clk);
        #1;
        check("stale_ack_depth", bus.depth, 0);
        check("stale_ack_state", dbg_state == ST_IDLE, 1);
        check("stale_ack_cmd_ready", bus.cmd_ready, 1);

        // random traffic
        for (int i = 0; i < 160; i++) begin
            rop = ($urandom_range(0, 9) < 4) ? OP_PUSHI : 3'($urandom_range(1, 7));
            send_cmd(rop, 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 19) == 0) ? 0 : -1, $urandom_range(1, 3));
        end
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
